// File: rtl/loader_pkg.sv
// Shared types and constants for rom_loader_packer and its write-buffer FIFO.
package loader_pkg;

    localparam logic [21:0] CSUM_START = 22'h200;
    localparam logic [21:0] CSUM_HDR   = 22'h18E;

    typedef struct packed {
        logic [20:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } fifo_entry_t;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

endpackage

// File: rtl/loader_fifo.sv
// Synchronous register FIFO with flush; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module loader_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0]
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);
    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; validity is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/rom_loader_packer.sv
// Packs loader bytes into big-endian words and writes them to SDRAM with a toggle handshake.
// Optional LOADER_CHECKSUM_EN adds the cartridge header checksum check (checksum_ok).
module rom_loader_packer
    import loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_BITS  = 22
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           loading,
    input  logic [7:0]           loader_do,
    input  logic                 loader_do_valid,
    output logic [ADDR_BITS-2:0] mem_addr,
    output logic [15:0]          mem_din,
    output logic [1:0]           mem_be,
    output logic                 mem_req,
    input  logic                 mem_ack,
    output logic [ADDR_BITS-1:0] rom_size,
    output logic                 md_on,
    output logic                 overflow
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic                 checksum_ok
`endif
);
    state_t                 wr_state_q, wr_state_d, sess_state_q, sess_state_d;
    logic                   loading_act_q;
    logic [ADDR_BITS:0]     cnt_q, cnt_d, cnt_cur;
    logic [7:0]             hi_q, hi_d;
    logic                   overflow_q, overflow_d, md_on_q, md_on_d;
    logic [ADDR_BITS-1:0]   rom_size_q, rom_size_d;
    logic [ADDR_BITS-2:0]   mem_addr_q, mem_addr_d;
    logic [15:0]            mem_din_q, mem_din_d;
    logic [1:0]             mem_be_q, mem_be_d;
    logic                   mem_req_q, mem_req_d;
    logic                   rise, fall, ack_match, wr_free;
    logic                   push, pop, flush, full, empty;
    fifo_entry_t            push_data, head;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]            sum_q, sum_d, hdr_q, hdr_d;
    logic                   csum_ok_q, csum_ok_d;
    logic [ADDR_BITS-1:0]   word_baddr;
`endif

    assign rise      = (loading != 3'd0) && !loading_act_q;
    assign fall      = (loading == 3'd0) && loading_act_q;
    assign ack_match = (mem_ack == mem_req_q);
    assign wr_free   = (wr_state_q == IDLE) || ack_match;

    always_comb begin
        wr_state_d   = wr_state_q;
        sess_state_d = sess_state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        overflow_d   = overflow_q;
        md_on_d      = md_on_q;
        rom_size_d   = rom_size_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_be_d     = mem_be_q;
        mem_req_d    = mem_req_q;
        push         = 1'b0;
        push_data    = '0;
        pop          = 1'b0;
        flush        = 1'b0;
        cnt_cur      = rise ? '0 : cnt_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
        hdr_d        = hdr_q;
        csum_ok_d    = csum_ok_q;
        word_baddr   = {cnt_cur[ADDR_BITS-1:1], 1'b0};
`endif

        // Session start discards buffered words but lets the in-flight write finish.
        if (rise) begin
            flush        = 1'b1;
            cnt_d        = '0;
            hi_d         = '0;
            overflow_d   = 1'b0;
            md_on_d      = 1'b0;
            sess_state_d = IDLE;
`ifdef LOADER_CHECKSUM_EN
            sum_d        = '0;
            hdr_d        = '0;
            csum_ok_d    = 1'b0;
`endif
        end

        if (loader_do_valid && (loading != 3'd0)) begin
            if (cnt_cur[ADDR_BITS]) begin
                overflow_d = 1'b1;
            end else begin
                cnt_d = cnt_cur + (ADDR_BITS+1)'(1);
                if (!cnt_cur[0]) begin
                    hi_d = loader_do;
                end else begin
                    push      = 1'b1;
                    push_data = '{addr: 21'(cnt_cur[ADDR_BITS-1:1]), data: {hi_q, loader_do}, be: 2'b11};
`ifdef LOADER_CHECKSUM_EN
                    if (word_baddr >= ADDR_BITS'(CSUM_START)) sum_d = sum_q + {hi_q, loader_do};
                    if (word_baddr == ADDR_BITS'(CSUM_HDR))   hdr_d = {hi_q, loader_do};
`endif
                end
            end
        end

        if (fall) begin
            sess_state_d = DRAIN;
            if (cnt_q[0]) begin
                push      = 1'b1;
                push_data = '{addr: 21'(cnt_q[ADDR_BITS-1:1]), data: {hi_q, 8'h00}, be: 2'b10};
            end
        end

        // Completion and the next pop share a cycle so one word issues per round trip.
        if (wr_free && !empty && !rise) begin
            pop        = 1'b1;
            mem_addr_d = (ADDR_BITS-1)'(head.addr);
            mem_din_d  = head.data;
            mem_be_d   = head.be;
            mem_req_d  = ~mem_req_q;
            wr_state_d = WAIT;
        end else if (wr_state_q == WAIT && ack_match) begin
            wr_state_d = IDLE;
        end

        if (push && full && !pop) overflow_d = 1'b1;

        if (sess_state_q == DRAIN && empty && !push && wr_free && !rise) begin
            rom_size_d   = cnt_q[ADDR_BITS-1:0];
            md_on_d      = 1'b1;
            sess_state_d = IDLE;
`ifdef LOADER_CHECKSUM_EN
            csum_ok_d    = (sum_q == hdr_q);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q    <= IDLE;
            sess_state_q  <= IDLE;
            loading_act_q <= 1'b0;
            cnt_q         <= '0;
            overflow_q    <= 1'b0;
            md_on_q       <= 1'b0;
            rom_size_q    <= '0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_be_q      <= '0;
            mem_req_q     <= mem_ack;
        end else begin
            wr_state_q    <= wr_state_d;
            sess_state_q  <= sess_state_d;
            loading_act_q <= (loading != 3'd0);
            cnt_q         <= cnt_d;
            overflow_q    <= overflow_d;
            md_on_q       <= md_on_d;
            rom_size_q    <= rom_size_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_be_q      <= mem_be_d;
            mem_req_q     <= mem_req_d;
        end
    end

    always_ff @(posedge clk) begin
        hi_q <= hi_d;
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q     <= '0;
            hdr_q     <= '0;
            csum_ok_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            hdr_q     <= hdr_d;
            csum_ok_q <= csum_ok_d;
        end
    end
    assign checksum_ok = csum_ok_q;
`endif

    loader_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fifo_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_be   = mem_be_q;
    assign mem_req  = mem_req_q;
    assign rom_size = rom_size_q;
    assign md_on    = md_on_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_rom_loader_packer.sv
// Directed bench for rom_loader_packer with a toggle-handshake SDRAM responder.
`timescale 1ns/1ps
module tb_rom_loader_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  loading;
    logic [7:0]  loader_do;
    logic        loader_do_valid;
    logic [20:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_be;
    logic        mem_req;
    logic        mem_ack;
    logic [21:0] rom_size;
    logic        md_on;
    logic        overflow;
`ifdef LOADER_CHECKSUM_EN
    logic        checksum_ok;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    bit          model_en  = 1'b0;
    int          ack_dly   = 3;
    int          proto_err = 0;
    logic [38:0] wlog[$];

    always #5 clk = ~clk;

    rom_loader_packer #(.FIFO_DEPTH(4), .ADDR_BITS(22)) dut (
        .clk             (clk),
        .reset           (reset),
        .loading         (loading),
        .loader_do       (loader_do),
        .loader_do_valid (loader_do_valid),
        .mem_addr        (mem_addr),
        .mem_din         (mem_din),
        .mem_be          (mem_be),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .rom_size        (rom_size),
        .md_on           (md_on),
        .overflow        (overflow)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum_ok     (checksum_ok)
`endif
    );

    // SDRAM responder: logs each request, acks ack_dly cycles later, flags instability.
    initial begin : sdram_model
        logic        r;
        logic [38:0] w;
        forever begin
            @(posedge clk); #1;
            if (model_en && (mem_req !== mem_ack)) begin
                r = mem_req;
                w = {mem_addr, mem_din, mem_be};
                wlog.push_back(w);
                for (int k = 0; k < ack_dly; k++) begin
                    @(posedge clk); #1;
                    if (mem_req !== r || {mem_addr, mem_din, mem_be} !== w) proto_err++;
                end
                mem_ack = r;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        loader_do       = b;
        loader_do_valid = 1'b1;
        tick();
        loader_do_valid = 1'b0;
    endtask

    task automatic wait_md_on(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (md_on === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; loading = 3'd0; loader_do = 8'h00; loader_do_valid = 1'b0; mem_ack = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL reset_mem_req: got %b want 1", mem_req); end
        n_cmp++; if (mem_addr !== 21'd0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_din !== 16'd0) begin n_bad++; $display("FAIL reset_mem_din: got %h want 0", mem_din); end
        n_cmp++; if (mem_be !== 2'd0) begin n_bad++; $display("FAIL reset_mem_be: got %b want 0", mem_be); end
        n_cmp++; if (rom_size !== 22'd0) begin n_bad++; $display("FAIL reset_rom_size: got %h want 0", rom_size); end
        n_cmp++; if (md_on !== 1'b0) begin n_bad++; $display("FAIL reset_md_on: got %b want 0", md_on); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_even_load();
        logic [38:0] exp_w [3];
        bit ok;
        exp_w[0] = {21'd0, 16'h1122, 2'b11};
        exp_w[1] = {21'd1, 16'h3344, 2'b11};
        exp_w[2] = {21'd2, 16'h5566, 2'b11};
        model_en = 1'b1; ack_dly = 3; wlog.delete();
        loading = 3'd1; tick();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        loading = 3'd0;
        wait_md_on(200, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL even_md_on: got %b want 1", md_on); end
        n_cmp++; if (wlog.size() != 3) begin n_bad++; $display("FAIL even_nwrites: got %0d want 3", wlog.size()); end
        for (int i = 0; i < 3 && i < wlog.size(); i++) begin
            n_cmp++; if (wlog[i] !== exp_w[i]) begin n_bad++; $display("FAIL even_write%0d: got %h want %h", i, wlog[i], exp_w[i]); end
        end
        n_cmp++; if (rom_size !== 22'd6) begin n_bad++; $display("FAIL even_rom_size: got %0d want 6", rom_size); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL even_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_odd_load();
        logic [38:0] exp_w [2];
        bit ok;
        exp_w[0] = {21'd0, 16'hAABB, 2'b11};
        exp_w[1] = {21'd1, 16'hCC00, 2'b10};
        ack_dly = 3; wlog.delete();
        loading = 3'd2; tick();
        n_cmp++; if (md_on !== 1'b0) begin n_bad++; $display("FAIL odd_md_on_cleared: got %b want 0", md_on); end
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        loading = 3'd0;
        wait_md_on(200, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL odd_md_on: got %b want 1", md_on); end
        n_cmp++; if (wlog.size() != 2) begin n_bad++; $display("FAIL odd_nwrites: got %0d want 2", wlog.size()); end
        for (int i = 0; i < 2 && i < wlog.size(); i++) begin
            n_cmp++; if (wlog[i] !== exp_w[i]) begin n_bad++; $display("FAIL odd_write%0d: got %h want %h", i, wlog[i], exp_w[i]); end
        end
        n_cmp++; if (rom_size !== 22'd3) begin n_bad++; $display("FAIL odd_rom_size: got %0d want 3", rom_size); end
    endtask

    task automatic test_overflow();
        logic [38:0] e;
        bit ok;
        ack_dly = 40; wlog.delete();
        loading = 3'd1; tick();
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        loading = 3'd0;
        wait_md_on(1000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovf_md_on: got %b want 1", md_on); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_cmp++; if (wlog.size() != 5) begin n_bad++; $display("FAIL ovf_nwrites: got %0d want 5", wlog.size()); end
        for (int k = 0; k < 5 && k < wlog.size(); k++) begin
            e = {21'(k), 8'(2*k), 8'(2*k+1), 2'b11};
            n_cmp++; if (wlog[k] !== e) begin n_bad++; $display("FAIL ovf_write%0d: got %h want %h", k, wlog[k], e); end
        end
        n_cmp++; if (rom_size !== 22'd16) begin n_bad++; $display("FAIL ovf_rom_size: got %0d want 16", rom_size); end
        n_cmp++; if (proto_err != 0) begin n_bad++; $display("FAIL ovf_one_outstanding: got %0d want 0", proto_err); end
    endtask

    task automatic test_drain_abort();
        logic [38:0] exp_w [2];
        bit ok;
        exp_w[0] = {21'd0, 16'h2122, 2'b11};
        exp_w[1] = {21'd0, 16'h0102, 2'b11};
        ack_dly = 20; wlog.delete();
        loading = 3'd1; tick();
        send_byte(8'h21); send_byte(8'h22); send_byte(8'h23);
        loading = 3'd0;
        repeat (3) tick();
        n_cmp++; if (md_on !== 1'b0) begin n_bad++; $display("FAIL abort_md_on_drain: got %b want 0", md_on); end
        loading = 3'd4;
        repeat (2) tick();
        n_cmp++; if (md_on !== 1'b0) begin n_bad++; $display("FAIL abort_md_on_restart: got %b want 0", md_on); end
        send_byte(8'h01); send_byte(8'h02);
        loading = 3'd0;
        wait_md_on(300, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_md_on: got %b want 1", md_on); end
        n_cmp++; if (wlog.size() != 2) begin n_bad++; $display("FAIL abort_nwrites: got %0d want 2", wlog.size()); end
        for (int i = 0; i < 2 && i < wlog.size(); i++) begin
            n_cmp++; if (wlog[i] !== exp_w[i]) begin n_bad++; $display("FAIL abort_write%0d: got %h want %h", i, wlog[i], exp_w[i]); end
        end
        n_cmp++; if (rom_size !== 22'd2) begin n_bad++; $display("FAIL abort_rom_size: got %0d want 2", rom_size); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL abort_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_reset_in_wait();
        bit   pend;
        logic r0;
        model_en = 1'b0;
        loading = 3'd1; tick();
        send_byte(8'h5A); send_byte(8'hA5);
        pend = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req !== mem_ack) begin pend = 1'b1; break; end
            tick();
        end
        n_cmp++; if (!pend) begin n_bad++; $display("FAIL rstwait_pending: got %b want 1", pend); end
        reset = 1'b1; loading = 3'd0;
        tick();
        reset = 1'b0;
        n_cmp++; if (mem_req !== mem_ack) begin n_bad++; $display("FAIL rstwait_req_eq_ack: got %b want %b", mem_req, mem_ack); end
        n_cmp++; if ({mem_addr, mem_din, mem_be} !== 39'd0) begin n_bad++; $display("FAIL rstwait_mem_zero: got %h want 0", {mem_addr, mem_din, mem_be}); end
        n_cmp++; if ({md_on, overflow, rom_size} !== 24'd0) begin n_bad++; $display("FAIL rstwait_status_zero: got %h want 0", {md_on, overflow, rom_size}); end
        r0 = mem_req;
        repeat (20) tick();
        n_cmp++; if (mem_req !== r0) begin n_bad++; $display("FAIL rstwait_no_spurious: got %b want %b", mem_req, r0); end
        model_en = 1'b1;
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] img [516];
        bit ok;
        for (int i = 0; i < 516; i++) img[i] = 8'h00;
        img[16'h18F] = 8'h03; img[16'h201] = 8'h01; img[16'h203] = 8'h02;
        ack_dly = 1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) img[16'h201] = 8'h02;
            loading = 3'd1; tick();
            for (int i = 0; i < 516; i++) begin send_byte(img[i]); tick(); end
            loading = 3'd0;
            wait_md_on(400, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL csum%0d_md_on: got %b want 1", pass, md_on); end
            n_cmp++; if (checksum_ok !== (pass == 0)) begin n_bad++; $display("FAIL csum%0d_ok: got %b want %b", pass, checksum_ok, pass == 0); end
            n_cmp++; if (rom_size !== 22'h204) begin n_bad++; $display("FAIL csum%0d_rom_size: got %h want 204", pass, rom_size); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_even_load();
        test_odd_load();
        test_overflow();
        test_drain_abort();
        test_reset_in_wait();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_loader_packer.md
# rom_loader_packer

Sits between the iosys ROM loader byte stream and SDRAM port 1, upstream of the SDRAM controller and the Mega Drive core. Packs big-endian byte pairs into 16-bit words and buffers them in a small FIFO. Issues toggle-handshake writes that respect SDRAM acknowledgement, and drains cleanly at end of load. Reports final ROM size and core-enable (`md_on`) to the system.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: word entries buffered; power of two, ≥2.
- `ADDR_BITS`, default 22: byte address width (4 MB ROM window).

Ports:
- `clk` in 1: system clock (`clk_sys`, 53.75 MHz); one clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `loading` in 3: iosys load mode; nonzero = load session active.
- `loader_do` in 8: ROM byte.
- `loader_do_valid` in 1: one-cycle strobe per byte.
- `mem_addr` out ADDR_BITS-1: SDRAM word address (`[21:1]`).
- `mem_din` out 16: write data, `{even byte, odd byte}`.
- `mem_be` out 2: byte enables; `[1]` = high/even byte.
- `mem_req` out 1: toggle request.
- `mem_ack` in 1: toggle acknowledge from SDRAM.
- `rom_size` out ADDR_BITS: byte count of the last completed load.
- `md_on` out 1: core run enable.
- `overflow` out 1: sticky; a byte or word was dropped.
- `checksum_ok` out 1: present only with `LOADER_CHECKSUM_EN`.

## Operation
- Reset values:
  - `mem_req` is loaded from `mem_ack`, so no request is pending after reset. The SDRAM side is not reset.
  - All other outputs are 0. FIFO is empty. FSM is in IDLE.
- Session start (`loading` goes from 0 to nonzero, detected against a registered copy):
  - Byte counter, pair register, FIFO and `overflow` are cleared.
  - `md_on` goes to 0.
  - An in-flight SDRAM request is allowed to complete and is not cancelled.
- Byte capture, when `loader_do_valid` is high and the counter is below 2^ADDR_BITS:
  - Even address: byte held in the high half of the pair register.
  - Odd address: word `{hi, byte}` pushed with `be=2'b11` at word address `cnt[21:1]`.
  - Counter increments every accepted byte.
  - Bytes at or beyond 4 MB are dropped, set `overflow`, and do not increment the counter.
- FIFO full on push: the word is dropped and `overflow` is set. Simultaneous push and pop on a full FIFO is legal and is not an overflow.
- Write FSM:
  - IDLE: if the FIFO is not empty, pop the head onto the `mem_*` registers, toggle `mem_req`, go to WAIT.
  - WAIT: when `mem_ack == mem_req`, go to IDLE.
  - Only one request is outstanding at any time. `mem_addr`, `mem_din` and `mem_be` are stable while in WAIT.
- Session end (`loading` goes from nonzero to 0): enter DRAIN.
  - If the byte count is odd, push the pending byte with `be=2'b10`.
  - When the FIFO is empty and the FSM is in IDLE: latch `rom_size` = counter, set `md_on` = 1.
- A new session start during DRAIN aborts the drain. The FIFO is flushed and `md_on` stays 0.
- A `loading` mode change between nonzero values is not an edge and is ignored.

## Timing
- A byte with `loader_do_valid` in cycle N is registered at the N+1 edge.
- For an odd byte, the FIFO push is visible in N+1.
- With the FIFO empty and the FSM in IDLE, `mem_req` toggles at the N+2 edge.
- An ack seen in cycle M lets the next request toggle at M+1. Sustained throughput is one word per SDRAM round trip.
- `md_on` rises one cycle after the last ack is observed in DRAIN. The same holds for an empty load.
- Back-to-back `loader_do_valid` on every cycle is legal.

## Configuration
- `LOADER_CHECKSUM_EN`:
  - Defined: the block accumulates a 16-bit wrapping sum of all full words at byte address ≥ 0x200. It captures the header word at 0x18E. `checksum_ok` = (sum == header) and is updated together with `md_on`. A partial final word is excluded from the sum. `checksum_ok` resets to 0 and clears at session start.
  - Undefined: the `checksum_ok` port and all checksum logic are absent.

## Structure
- `loader_pkg` contains:
  - the FIFO entry struct `{addr[20:0], data[15:0], be[1:0]}`;
  - the FSM enum {IDLE, WAIT, DRAIN};
  - the constants `CSUM_START = 22'h200` and `CSUM_HDR = 22'h18E`.
- Sub-module `loader_fifo`: synchronous register FIFO with push, pop, full, empty and flush, parameterised by depth and the entry type.

## Test plan
- Load 6 bytes 0x11..0x66 with ack 3 cycles after each req → writes (0,0x1122,11), (1,0x3344,11), (2,0x5566,11); `rom_size=6`; `md_on=1`.
- Load 3 bytes 0xAA 0xBB 0xCC → final write (1,0xCC00,10); `rom_size=3`.
- Bytes every cycle with ack delayed 40 cycles, FIFO_DEPTH=4 → `overflow=1`; no more than one outstanding request; all retained words in order.
- Assert `reset` while in WAIT with `mem_ack != mem_req` → outputs 0 and `mem_req == mem_ack` next cycle; no spurious write afterwards.
- New session start during DRAIN → FIFO flushed, `md_on` stays 0, counter restarts at 0.
- With `LOADER_CHECKSUM_EN`: 0x204-byte image, header 0x18E = 0x0003, words at 0x200/0x202 = 0x0001/0x0002 → `checksum_ok=1`; flipping one byte gives 0.
